// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, opcodes, instruction field positions and front-end FSM states
// for the 8-bit accumulator CPU.
package cpu_pkg;
    localparam int AW_DEF = 5;
    localparam int DW_DEF = 8;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_DBL = 2'b01;
    localparam logic [1:0] OP_LDA = 2'b10;
    localparam logic [1:0] OP_CMA = 2'b11;
    localparam int IND_BIT = 7;
    localparam int OP_MSB  = 6;
    localparam int OP_LSB  = 5;
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, INDIRECT, ISSUE} state_t;
endpackage

// File: rtl/fetch_imem.sv
// fetch_imem: 2**AW x DW register-array memory, one write port, two combinational reads.
// Port b returns only the address bits, since it is used solely for indirect pointers.
module fetch_imem #(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [AW-1:0] rdata_b
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
        else if (we)
            mem[waddr] <= wdata;

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b][AW-1:0];
endmodule

// File: rtl/fetch_decode_unit.sv
// fetch_decode_unit: PC, program memory and fetch/decode/indirect FSM; issues
// {op, indirect, effective address, pc} to the execute stage over valid/ready.
module fetch_decode_unit
    import cpu_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_data,
    input  logic          start,
    input  logic [AW-1:0] start_pc,
    input  logic          stop,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [1:0]    out_op,
    output logic          out_ind,
    output logic [AW-1:0] out_addr,
    output logic [AW-1:0] out_pc,
    output logic          busy
);
    state_t state, state_next;
    logic [AW-1:0] pc, fpc, ar, ar_next, ptr;
    logic [DW-1:0] ir, word;
    logic stop_pend, issue_next;
    logic [1:0] op_next;
    logic ind_next;
    logic [AW-1:0] addr_next, pc_next;

    fetch_imem #(.AW(AW), .DW(DW)) u_mem (
        .clk(clk), .rst_n(rst_n),
        .we(load_en && state == IDLE), .waddr(load_addr), .wdata(load_data),
        .raddr_a(pc), .rdata_a(word),
        .raddr_b(ar), .rdata_b(ptr)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= '0;
            fpc       <= '0;
            ir        <= '0;
            ar        <= '0;
            stop_pend <= 1'b0;
            out_valid <= 1'b0;
            out_op    <= '0;
            out_ind   <= 1'b0;
            out_addr  <= '0;
            out_pc    <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start)
                pc <= start_pc;
            else if (state == FETCH)
                pc <= pc + AW'(1);
            if (state == FETCH) begin
                ir  <= word;
                fpc <= pc;
            end
            ar        <= ar_next;
            stop_pend <= state_next == IDLE ? 1'b0 : stop_pend | (state != IDLE && stop);
            out_valid <= issue_next;
            out_op    <= op_next;
            out_ind   <= ind_next;
            out_addr  <= addr_next;
            out_pc    <= pc_next;
        end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     state_next = start ? FETCH : IDLE;
            FETCH:    state_next = DECODE;
            DECODE:   state_next = ir[IND_BIT] ? INDIRECT : ISSUE;
            INDIRECT: state_next = ISSUE;
            ISSUE:    if (out_valid && out_ready) state_next = (stop_pend || stop) ? IDLE : FETCH;
            default:  state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they appear on the edge that enters ISSUE.
    always_comb begin
        ar_next    = state == DECODE ? ir[AW-1:0] : state == INDIRECT ? ptr : ar;
        issue_next = state_next == ISSUE;
        op_next    = issue_next ? ir[OP_MSB:OP_LSB] : '0;
        ind_next   = issue_next ? ir[IND_BIT] : 1'b0;
        addr_next  = issue_next ? ar_next : '0;
        pc_next    = issue_next ? fpc : '0;
    end

    assign busy = state != IDLE;
endmodule

// File: tb/tb_fetch_decode_unit.sv
// tb_fetch_decode_unit: directed stimulus pushes expected issues into a queue; a negedge
// monitor pops and compares on every accepted handshake.
module tb_fetch_decode_unit;
    import cpu_pkg::*;

    logic clk = 0, rst_n = 0, load_en = 0, start = 0, stop = 0, out_ready = 0;
    logic [4:0] load_addr = 0, start_pc = 0;
    logic [7:0] load_data = 0;
    logic out_valid, out_ind, busy;
    logic [1:0] out_op;
    logic [4:0] out_addr, out_pc;
    int n_chk = 0, n_fail = 0;
    logic [12:0] q[$];

    fetch_decode_unit dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .start_pc(start_pc), .stop(stop),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_ind(out_ind),
        .out_addr(out_addr), .out_pc(out_pc), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] pk(logic [1:0] op, logic ind, logic [4:0] a, logic [4:0] p);
        return {op, ind, a, p};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        rst_n = 0; load_en = 0; start = 0; stop = 0; out_ready = 0;
        q.delete();
        repeat (2) tick;
        rst_n = 1;
        check("reset_busy", busy, 0);
        check("reset_valid", out_valid, 0);
    endtask

    task automatic load(logic [4:0] a, logic [7:0] d);
        load_en = 1; load_addr = a; load_data = d;
        tick;
        load_en = 0;
    endtask

    task automatic go(logic [4:0] p);
        start = 1; start_pc = p;
        tick;
        start = 0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            tick;
            n++;
        end
    endtask

    always @(negedge clk) if (rst_n) begin
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_issue: got %h expected none", {out_op, out_ind, out_addr, out_pc});
            end else
                check("issue", {out_op, out_ind, out_addr, out_pc}, q.pop_front());
        end else if (!out_valid)
            check("idle_zero", {out_op, out_ind, out_addr, out_pc}, 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        // 1: async reset in the middle of a stalled ISSUE
        do_reset;
        load(5'd1, 8'h45);
        q.push_back(pk(OP_LDA, 0, 5'd5, 5'd1));
        go(5'd1);
        wait_valid(n);
        check("t1_valid", out_valid, 1);
        #1 rst_n = 0;
        #1;
        check("t1_rst_valid", out_valid, 0);
        check("t1_rst_busy", busy, 0);
        check("t1_rst_pc", dut.pc, 0);
        check("t1_rst_outpc", out_pc, 0);
        q.delete();
        tick;
        rst_n = 1;

        // 2: direct issue, then next sequential fetch from 2
        do_reset;
        load(5'd1, 8'h45);
        out_ready = 1;
        q.push_back(pk(OP_LDA, 0, 5'd5, 5'd1));
        q.push_back(pk(OP_ADD, 0, 5'd0, 5'd2));
        go(5'd1);
        wait_valid(n);
        check("t2_latency", n, 2);
        tick;
        stop = 1;
        wait_valid(n);
        check("t2_b2b_latency", n, 2);
        stop = 0;
        tick;
        check("t2_idle", busy, 0);

        // 3: indirect
        do_reset;
        load(5'd0, 8'h83);
        load(5'd3, 8'hF4);
        out_ready = 1;
        q.push_back(pk(OP_ADD, 1, 5'h14, 5'd0));
        go(5'd0);
        stop = 1;
        wait_valid(n);
        stop = 0;
        check("t3_latency", n, 3);
        tick;
        check("t3_idle", busy, 0);

        // 4: backpressure for 5 cycles
        do_reset;
        load(5'd1, 8'h45);
        q.push_back(pk(OP_LDA, 0, 5'd5, 5'd1));
        go(5'd1);
        wait_valid(n);
        for (int i = 0; i < 5; i++) begin
            tick;
            check("t4_hold_valid", out_valid, 1);
            check("t4_hold_out", {out_op, out_ind, out_addr, out_pc}, pk(OP_LDA, 0, 5'd5, 5'd1));
            check("t4_hold_pc", dut.pc, 2);
        end
        out_ready = 1; stop = 1;
        tick;
        stop = 0;
        check("t4_idle", busy, 0);

        // 5: pc wrap and stop during the second DECODE
        do_reset;
        load(5'd31, 8'h40);
        load(5'd0, 8'h21);
        out_ready = 1;
        q.push_back(pk(OP_LDA, 0, 5'd0, 5'd31));
        q.push_back(pk(OP_DBL, 0, 5'd1, 5'd0));
        go(5'd31);
        wait_valid(n);
        tick;
        tick;
        stop = 1;
        tick;
        stop = 0;
        check("t5_second_valid", out_valid, 1);
        tick;
        check("t5_idle", busy, 0);
        check("t5_pc", dut.pc, 1);
        repeat (3) begin
            tick;
            check("t5_no_fetch", busy, 0);
        end

        // 6: load_en while busy must not change memory
        do_reset;
        load(5'd1, 8'h45);
        load(5'd2, 8'h2A);
        out_ready = 1;
        q.push_back(pk(OP_LDA, 0, 5'd5, 5'd1));
        q.push_back(pk(OP_DBL, 0, 5'h0A, 5'd2));
        go(5'd1);
        load_en = 1; load_addr = 5'd2; load_data = 8'hFF;
        wait_valid(n);
        tick;
        stop = 1;
        wait_valid(n);
        load_en = 0; stop = 0;
        tick;
        check("t6_idle", busy, 0);
        check("t6_mem", dut.u_mem.mem[2], 8'h2A);

        tick;
        check("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
